// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite constants and the bridge state encoding.
// Imported by the CPU-to-AXI bridge and the interconnect.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int PROT_PRIV  = 0;
  localparam int PROT_NSEC  = 1;
  localparam int PROT_INSTR = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5,
    DRAIN = 3'd6
  } state_t;

  // Secure, unprivileged; only the instruction bit varies.
  function automatic logic [2:0] mk_prot(input logic instr);
    logic [2:0] p;
    p = 3'b000;
    p[PROT_INSTR] = instr;
    return p;
  endfunction

endpackage

// File: rtl/mem_to_axi4lite_master.sv
// CPU native memory bus to AXI4-Lite master bridge.
// One outstanding transaction, with timeout and post-timeout drain.
module mem_to_axi4lite_master
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  bus_err,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp
);

  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int TW = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST =
    TW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state;
  state_t        dr_phase;
  state_t        phase;
  state_t        nxt;
  logic          draining;
  logic          err;
  logic          adv;
  logic          expired;
  logic [TW-1:0] timer;

  // During a drain the bus phase continues while state sits in DONE/DRAIN.
  always_comb begin
    phase = draining ? dr_phase : state;
    adv   = 1'b0;
    nxt   = IDLE;
    case (phase)
      WADDR: begin
        adv = (!m_axi_awvalid || m_axi_awready) &&
              (!m_axi_wvalid  || m_axi_wready);
        nxt = WRESP;
      end
      WRESP: begin
        adv = m_axi_bvalid && m_axi_bready;
        nxt = DONE;
      end
      RADDR: begin
        adv = m_axi_arvalid && m_axi_arready;
        nxt = RDATA;
      end
      RDATA: begin
        adv = m_axi_rvalid && m_axi_rready;
        nxt = DONE;
      end
      default: ;
    endcase
  end

  assign expired = TO_EN && (timer >= T_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      dr_phase      <= IDLE;
      draining      <= 1'b0;
      err           <= 1'b0;
      timer         <= '0;
      mem_ready     <= 1'b0;
      mem_rdata     <= '0;
      bus_err       <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awprot  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arprot  <= '0;
      m_axi_rready  <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;

      if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
      if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;
      if (m_axi_bvalid && m_axi_bready)   m_axi_bready  <= 1'b0;
      if (m_axi_rvalid && m_axi_rready)   m_axi_rready  <= 1'b0;

      if (adv) begin
        if (phase == WADDR) m_axi_bready <= 1'b1;
        if (phase == RADDR) m_axi_rready <= 1'b1;
        if (phase == RDATA && !draining) begin
          err       <= (m_axi_rresp != RESP_OKAY);
          mem_rdata <= (m_axi_rresp != RESP_OKAY) ?
                       ERR_RDATA : m_axi_rdata;
        end
        if (draining) dr_phase <= (nxt == DONE) ? IDLE : nxt;
      end

      case (state)
        IDLE: begin
          timer <= '0;
          err   <= 1'b0;
          if (mem_valid && !mem_ready) begin
            m_axi_awaddr <= mem_addr;
            m_axi_araddr <= mem_addr;
            m_axi_awprot <= mk_prot(mem_instr);
            m_axi_arprot <= mk_prot(mem_instr);
            m_axi_wdata  <= mem_wdata;
            m_axi_wstrb  <= mem_wstrb;
            if (|mem_wstrb) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WADDR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RADDR;
            end
          end
        end
        WADDR, WRESP, RADDR, RDATA: begin
          if (timer != T_MAX) timer <= timer + TW'(1);
          if (adv) begin
            state <= nxt;
          end else if (expired) begin
            state     <= DONE;
            draining  <= 1'b1;
            dr_phase  <= state;
            mem_rdata <= ERR_RDATA;
            err       <= 1'b1;
          end
        end
        DONE: begin
          mem_ready <= 1'b1;
          bus_err   <= err;
          state     <= draining ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (dr_phase == IDLE) begin
            draining <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_to_axi4lite_master.sv
// Scoreboard bench for mem_to_axi4lite_master with a behavioural
// AXI4-Lite slave and a reference memory model.
module tb_mem_to_axi4lite_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid, mem_instr, mem_ready, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  rresp;

  always #5 clk = ~clk;

  mem_to_axi4lite_master #(
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(8),
    .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .bus_err(bus_err),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp)
  );

  typedef struct {
    bit          wr;
    int          d1, d2, d3;
    logic [1:0]  rr;
    logic [31:0] addr, wd;
    logic [3:0]  ws;
    logic [2:0]  prot;
  } plan_t;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] rd;
  } exp_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  logic [31:0] slv_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          aw_cyc, w_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
    input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    if (slv_mem.exists(a)) return slv_mem[a];
    return dflt(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slv_idle();
    awready = 0; wready = 0; bvalid = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
  endtask

  task automatic wait_ready(input logic is_b);
    logic h;
    h = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      h = is_b ? bready : rready;
      tick();
      if (h || !resetn) break;
    end
    if (resetn) chk(is_b ? "b_hs" : "r_hs", 32'(h), 32'd1);
  endtask

  task automatic serve_read(input plan_t p);
    logic [31:0] a;
    chk("ar_kind", 32'(arvalid), 32'd1);
    for (int i = 0; i < p.d1 && resetn; i++) tick();
    if (!resetn) return;
    arready = 1;
    a = araddr;
    chk("araddr", araddr, p.addr);
    chk("arprot", 32'(arprot), 32'(p.prot));
    tick();
    arready = 0;
    for (int i = 0; i < p.d2 && resetn; i++) tick();
    if (!resetn) return;
    rvalid = 1;
    rresp = p.rr;
    rdata = slv_rd(a);
    wait_ready(1'b0);
    rvalid = 0;
  endtask

  task automatic serve_write(input plan_t p);
    bit ad, wdn;
    int c;
    logic [31:0] a, d;
    logic [3:0] s;
    ad = 0; wdn = 0; c = 0;
    a = '0; d = '0; s = '0;
    while (!(ad && wdn) && resetn && c < 200) begin
      awready = !ad && c >= p.d1;
      wready = !wdn && c >= p.d2;
      if (awready) begin
        a = awaddr;
        chk("awaddr", awaddr, p.addr);
        chk("awprot", 32'(awprot), 32'(p.prot));
      end
      if (wready) begin
        d = wdata;
        s = wstrb;
        chk("wdata", wdata, p.wd);
        chk("wstrb", 32'(wstrb), 32'(p.ws));
      end
      tick();
      if (awready) begin ad = 1; aw_cyc = cyc; end
      if (wready) begin wdn = 1; w_cyc = cyc; end
      c++;
    end
    awready = 0;
    wready = 0;
    for (int i = 0; i < p.d3 && resetn; i++) tick();
    if (!resetn) return;
    bvalid = 1;
    wait_ready(1'b1);
    bvalid = 0;
    if (resetn) slv_mem[a] = merge(slv_rd(a), d, s);
  endtask

  initial begin : slave
    plan_t p;
    slv_idle();
    forever begin
      tick();
      if (!resetn) begin
        slv_idle();
        plan_q.delete();
      end else if ((arvalid || awvalid || wvalid) &&
                   plan_q.size() > 0) begin
        p = plan_q.pop_front();
        if (p.wr) serve_write(p);
        else serve_read(p);
        slv_idle();
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn) begin
      if (mem_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ready", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("bus_err", 32'(bus_err), 32'(e.err));
          if (!e.wr || e.err) chk("mem_rdata", mem_rdata, e.rd);
        end
      end else if (bus_err) begin
        chk("err_alone", 32'd1, 32'd0);
      end
    end
  end

  task automatic mk_plan(input bit wr, input bit instr,
    input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
    input int d1, input int d2, input int d3, input logic [1:0] rr,
    output plan_t p);
    p.wr = wr; p.d1 = d1; p.d2 = d2; p.d3 = d3; p.rr = rr;
    p.addr = a; p.wd = d; p.ws = wr ? s : 4'b0000;
    p.prot = {instr, 2'b00};
  endtask

  task automatic req(input bit wr, input bit instr,
    input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
    input int d1, input int d2, input int d3, input logic [1:0] rr,
    input bit tmo, output int lat);
    plan_t p;
    exp_t e;
    int t0;
    bit got;
    mk_plan(wr, instr, a, d, s, d1, d2, d3, rr, p);
    e.wr = wr;
    e.err = tmo || (!wr && rr != 2'b00);
    e.rd = e.err ? 32'hDEAD_BEEF : ref_rd(a);
    if (wr && !tmo) ref_mem[a] = merge(ref_rd(a), d, s);
    plan_q.push_back(p);
    exp_q.push_back(e);
    mem_valid = 1; mem_instr = instr; mem_addr = a;
    mem_wdata = d; mem_wstrb = p.ws;
    t0 = cyc;
    got = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (mem_ready) begin got = 1; break; end
    end
    chk("ready_seen", 32'(got), 32'd1);
    lat = cyc - t0 - 1;
    tick();
    mem_valid = 0;
    mem_wstrb = 0;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_awvalid"}, 32'(awvalid), 32'd0);
    chk({tag, "_wvalid"}, 32'(wvalid), 32'd0);
    chk({tag, "_bready"}, 32'(bready), 32'd0);
    chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
    chk({tag, "_rready"}, 32'(rready), 32'd0);
    chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
  endtask

  initial begin : driver
    int lat;
    plan_t p;
    logic [31:0] a;
    bit wr;
    logic [1:0] rr;
    mem_valid = 0; mem_instr = 0; mem_addr = '0;
    mem_wdata = '0; mem_wstrb = '0;
    repeat (3) tick();
    chk_idle_bus("reset");
    resetn = 1;
    slv_mem[32'h1000_0004] = 32'h1234_5678;
    ref_mem[32'h1000_0004] = 32'h1234_5678;

    req(0, 0, 32'h1000_0004, 0, 0, 0, 0, 0, 2'b00, 0, lat);
    chk("t1_lat", 32'(lat), 32'd3);

    req(1, 0, 32'h0000_0010, 32'hA5A5_A5A5, 4'b0011,
        2, 0, 1, 2'b00, 0, lat);
    chk("t2_w_before_aw", 32'(w_cyc < aw_cyc), 32'd1);
    req(0, 0, 32'h0000_0010, 0, 0, 0, 0, 0, 2'b00, 0, lat);

    req(0, 1, 32'h0000_0020, 0, 0, 1, 1, 0, 2'b00, 0, lat);
    req(1, 0, 32'h0000_0024, 32'h0BAD_F00D, 4'b1111,
        0, 0, 0, 2'b00, 0, lat);
    chk("t3_wr_lat", 32'(lat), 32'd3);

    req(0, 0, 32'h1000_0004, 0, 0, 0, 0, 0, 2'b10, 0, lat);

    req(0, 0, 32'h0000_0040, 0, 0, 12, 0, 0, 2'b00, 1, lat);
    chk("t5_lat", 32'(lat), 32'd9);
    chk("t5_arvalid_held", 32'(arvalid), 32'd1);
    req(0, 0, 32'h1000_0004, 0, 0, 0, 0, 0, 2'b00, 0, lat);

    mk_plan(1, 0, 32'h0000_0050, 32'h1111_2222, 4'b1111,
            0, 0, 5, 2'b00, p);
    plan_q.push_back(p);
    mem_valid = 1; mem_instr = 0; mem_addr = p.addr;
    mem_wdata = p.wd; mem_wstrb = p.ws;
    repeat (3) tick();
    chk("t6_in_wresp", 32'(bready), 32'd1);
    #2 resetn = 0;
    #1 chk_idle_bus("t6");
    mem_valid = 0;
    mem_wstrb = 0;
    repeat (3) tick();
    resetn = 1;
    req(0, 0, 32'h1000_0004, 0, 0, 0, 0, 0, 2'b00, 0, lat);
    req(1, 0, 32'h0000_0050, 32'hCAFE_0001, 4'b1100,
        0, 1, 0, 2'b00, 0, lat);
    req(0, 0, 32'h0000_0050, 0, 0, 0, 0, 0, 2'b00, 0, lat);

    for (int i = 0; i < 40; i++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 4) == 0) ?
           {1'b1, 1'($urandom_range(0, 1))} : 2'b00;
      req(wr, wr ? 1'b0 : 1'($urandom_range(0, 1)), a, $urandom,
          4'($urandom_range(1, 15)), $urandom_range(0, 2),
          $urandom_range(0, 2), $urandom_range(0, 2), rr, 0, lat);
    end

    for (int k = 0; k < 100 && exp_q.size() > 0; k++) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
